// File: rtl/flash_burst_reader_pkg.sv
// Shared types and default sizing for the flash burst-read sequencer.
package flash_burst_reader_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int STRIDE_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_REQ   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

endpackage

// File: rtl/flash_burst_reader_if.sv
// Command, flash request and output stream signals of the burst reader.
interface flash_burst_reader_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int DEPTH  = 8
) ();
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              flash_en;
    logic              flash_write;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_rdata;
    logic              flash_ack;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [LVL_W-1:0]  level;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, abort, flash_rdata, flash_ack, m_ready,
        output cmd_ready, busy, done, flash_en, flash_write, flash_addr, m_valid, m_data, level
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, abort, flash_rdata, flash_ack, m_ready,
        input  cmd_ready, busy, done, flash_en, flash_write, flash_addr, m_valid, m_data, level
    );
endinterface

// File: rtl/flash_burst_reader_fifo.sv
// DEPTH x DATA_W synchronous FIFO; occupancy is the difference of wrap-extended counters.
module flash_burst_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW:0]       wr_q, wr_d;
    logic [PW:0]       rd_q, rd_d;
    logic              pop_s;

    assign level_o = wr_q - rd_q;
    assign valid_o = (level_o != '0);
    assign data_o  = mem_q[rd_q[PW-1:0]];
    assign pop_s   = pop_i && valid_o;

    // Pointer next-state; flush wins over any concurrent push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) begin
                wr_d = wr_q + {{PW{1'b0}}, 1'b1};
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = rd_q + {{PW{1'b0}}, 1'b1};
            end else begin
                rd_d = rd_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (push_i && !reset) begin
            mem_q[wr_q[PW-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/flash_burst_reader.sv
// Burst-read sequencer: issues single-word flash reads for a {base, count} command and
// buffers the returned words in a FIFO drained over a valid/ready stream.
module flash_burst_reader
    import flash_burst_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    flash_burst_reader_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              pend_q, pend_d;
    logic              push_s;
    logic              flush_s;
    logic [LVL_W-1:0]  level_s;

    // FSM next-state; pend tracks a read still owed an ack while aborting.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        pend_d  = pend_q;
        push_s  = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    rem_d   = bus.cmd_len;
                    state_d = (bus.cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.abort) begin
                    pend_d  = 1'b0;
                    state_d = ST_ABORT;
                end else if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (level_s < LVL_W'(DEPTH)) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_REQ: begin
                if (bus.abort) begin
                    pend_d  = !bus.flash_ack;
                    state_d = ST_ABORT;
                end else if (bus.flash_ack) begin
                    push_s  = 1'b1;
                    addr_d  = addr_q + ADDR_W'(STRIDE);
                    rem_d   = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
                    state_d = (rem_q > {{(LEN_W-1){1'b0}}, 1'b1}) ? ST_ISSUE : ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                // The late ack's data is dropped: push_s stays low here.
                if (!pend_q || bus.flash_ack) begin
                    pend_d  = 1'b0;
                    flush_s = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.flash_en    = (state_q == ST_REQ) || ((state_q == ST_ABORT) && pend_q);
    assign bus.flash_write = 1'b0;
    assign bus.flash_addr  = addr_q;
    assign bus.level       = level_s;

    flash_burst_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .data_i  (bus.flash_rdata),
        .pop_i   (bus.m_ready),
        .flush_i (flush_s),
        .data_o  (bus.m_data),
        .valid_o (bus.m_valid),
        .level_o (level_s)
    );
endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed scoreboard bench for flash_burst_reader with a modelled flash controller.
module tb_flash_burst_reader;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 8;
    localparam int STRIDE = 4;

    logic clk;
    logic reset;

    flash_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) bus ();

    flash_burst_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH),
        .STRIDE (STRIDE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int n_popped = 0;
    int n_issued = 0;
    int wait_cnt = 0;
    int ack_dly  = 5;
    bit resp_en  = 1'b1;

    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock step; the controller model acks after ack_dly cycles of flash_en.
    task automatic tick();
        logic [ADDR_W-1:0] ea;
        @(posedge clk);
        #1;
        bus.flash_ack = 1'b0;
        if (resp_en && bus.flash_en) begin
            wait_cnt++;
            if (wait_cnt >= ack_dly) begin
                wait_cnt = 0;
                n_issued++;
                check("addr_expected", 64'(addr_q.size() != 0), 64'd1);
                if (addr_q.size() != 0) begin
                    ea = addr_q.pop_front();
                    check("flash_addr", 64'(bus.flash_addr), 64'(ea));
                end
                bus.flash_ack   = 1'b1;
                bus.flash_rdata = {8'hA5, bus.flash_addr};
                exp_data_q.push_back({8'hA5, bus.flash_addr});
            end
        end
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + ADDR_W'(i * STRIDE);
            addr_q.push_back(a);
        end
        check("cmd_ready_pre", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = base;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (exp_data_q.size() == 0 && !bus.m_valid) break;
            tick();
        end
        check(tag, 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
        check({tag, "_done"},      64'(bus.done), 64'd0);
        check({tag, "_flash_en"},  64'(bus.flash_en), 64'd0);
        check({tag, "_flash_wr"},  64'(bus.flash_write), 64'd0);
        check({tag, "_flash_addr"}, 64'(bus.flash_addr), 64'd0);
        check({tag, "_m_valid"},   64'(bus.m_valid), 64'd0);
        check({tag, "_level"},     64'(bus.level), 64'd0);
    endtask

    // Stream-side scoreboard: pop on every accepted beat, count done pulses.
    always @(negedge clk) begin
        if (!reset && bus.done) done_cnt++;
        if (!reset && bus.m_valid && bus.m_ready) begin
            check("sb_nonempty", 64'(exp_data_q.size() != 0), 64'd1);
            if (exp_data_q.size() != 0) begin
                check("m_data", 64'(bus.m_data), 64'(exp_data_q.pop_front()));
            end
            n_popped++;
        end
    end

    initial begin
        int d0;
        int i0;
        int p0;
        bit seen;
        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.abort       = 1'b0;
        bus.flash_rdata = '0;
        bus.flash_ack   = 1'b0;
        bus.m_ready     = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Three-word burst, consumer always ready.
        d0 = done_cnt;
        i0 = n_issued;
        start_cmd(24'h000100, 16'd3);
        wait_done("burst3_done", 100);
        tick();
        check("burst3_one_done", 64'(done_cnt - d0), 64'd1);
        wait_drain("burst3_drain", 20);
        check("burst3_reads", 64'(n_issued - i0), 64'd3);
        check("burst3_addr_q", 64'(addr_q.size()), 64'd0);

        // Zero-length command.
        i0 = n_issued;
        start_cmd(24'h000400, 16'd0);
        check("len0_done", 64'(bus.done), 64'd1);
        check("len0_flash_en", 64'(bus.flash_en), 64'd0);
        tick();
        check("len0_busy_drop", 64'(bus.busy), 64'd0);
        check("len0_done_drop", 64'(bus.done), 64'd0);
        check("len0_no_reads", 64'(n_issued - i0), 64'd0);

        // Address wrap at top of the address space.
        start_cmd(24'hFFFFFC, 16'd2);
        wait_done("wrap_done", 100);
        tick();
        wait_drain("wrap_drain", 20);
        check("wrap_addr_q", 64'(addr_q.size()), 64'd0);

        // Backpressure: FIFO fills to DEPTH, then the rest flows once drained.
        bus.m_ready = 1'b0;
        i0 = n_issued;
        p0 = n_popped;
        start_cmd(24'h001000, 16'd20);
        repeat (120) tick();
        check("bp_reads_stalled", 64'(n_issued - i0), 64'd8);
        check("bp_flash_en_low", 64'(bus.flash_en), 64'd0);
        check("bp_level_full", 64'(bus.level), 64'd8);
        bus.m_ready = 1'b1;
        wait_done("bp_done", 600);
        tick();
        wait_drain("bp_drain", 40);
        check("bp_reads_total", 64'(n_issued - i0), 64'd20);
        check("bp_words_out", 64'(n_popped - p0), 64'd20);

        // Abort with a read outstanding; ack arrives late and is discarded.
        bus.m_ready = 1'b0;
        start_cmd(24'h000200, 16'd5);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (bus.flash_en && bus.level == 4'd1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reach_req", 64'(seen), 64'd1);
        resp_en   = 1'b0;
        wait_cnt  = 0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_hold_en", 64'(bus.flash_en), 64'd1);
        check("abort_no_done", 64'(bus.done), 64'd0);
        tick();
        check("abort_hold_en2", 64'(bus.flash_en), 64'd1);
        check("abort_level_kept", 64'(bus.level), 64'd1);
        bus.flash_ack   = 1'b1;
        bus.flash_rdata = 32'hDEADBEEF;
        tick();
        check("abort_done", 64'(bus.done), 64'd1);
        check("abort_flushed", 64'(bus.level), 64'd0);
        check("abort_m_valid", 64'(bus.m_valid), 64'd0);
        check("abort_en_low", 64'(bus.flash_en), 64'd0);
        tick();
        check("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        exp_data_q.delete();
        addr_q.delete();
        resp_en     = 1'b1;
        bus.m_ready = 1'b1;

        // Reset mid-read followed by a stray ack.
        resp_en = 1'b0;
        start_cmd(24'h000300, 16'd2);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus.flash_en) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("rst_reach_req", 64'(seen), 64'd1);
        reset = 1'b1;
        tick();
        reset           = 1'b0;
        bus.flash_ack   = 1'b1;
        bus.flash_rdata = 32'h12345678;
        tick();
        check_idle_outputs("rst_mid");
        tick();
        check("rst_no_push", 64'(bus.m_valid), 64'd0);
        addr_q.delete();
        wait_cnt = 0;
        resp_en  = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
